// File: rtl/fft_bfly_pre_sat.sv
// Radix-2 delay-feedback butterfly ahead of the saturation stage.
// Buffers half a frame, then emits full-precision sum/difference lanes.
module fft_bfly_pre_sat #(
   parameter int WIDTH      = 13,
   parameter int DOUT_WIDTH = 14,
   parameter int DEPTH      = 4,
   parameter int HALF_BLKS  = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         sync,
   input  logic                         din_valid,
   input  logic signed [WIDTH-1:0]      din_R [DEPTH],
   input  logic signed [WIDTH-1:0]      din_Q [DEPTH],
   output logic                         dout_valid,
   output logic                         dout_last,
   output logic signed [DOUT_WIDTH-1:0] dout_R_add [DEPTH],
   output logic signed [DOUT_WIDTH-1:0] dout_R_sub [DEPTH],
   output logic signed [DOUT_WIDTH-1:0] dout_Q_add [DEPTH],
   output logic signed [DOUT_WIDTH-1:0] dout_Q_sub [DEPTH]
);

   localparam int NPH = 2 * HALF_BLKS;
   localparam int PW  = (NPH > 2) ? $clog2(NPH) : 1;
   localparam int SW  = (HALF_BLKS > 1) ? $clog2(HALF_BLKS) : 1;
   localparam logic [PW-1:0] LAST_PH = PW'(NPH - 1);
   localparam logic [PW-1:0] HB      = PW'(HALF_BLKS);

   logic [PW-1:0]           r_phase;
   logic signed [WIDTH-1:0] r_buf_R [HALF_BLKS][DEPTH];
   logic signed [WIDTH-1:0] r_buf_Q [HALF_BLKS][DEPTH];

   logic                         w_acc;
   logic                         w_fill;
   logic                         w_comb;
   logic                         w_wr;
   logic [SW-1:0]                w_slot;
   logic [SW-1:0]                w_wr_slot;
   logic [PW-1:0]                w_nxt;
   logic signed [DOUT_WIDTH-1:0] w_R_add [DEPTH];
   logic signed [DOUT_WIDTH-1:0] w_R_sub [DEPTH];
   logic signed [DOUT_WIDTH-1:0] w_Q_add [DEPTH];
   logic signed [DOUT_WIDTH-1:0] w_Q_sub [DEPTH];

   function automatic logic signed [DOUT_WIDTH-1:0] sx(
      input logic signed [WIDTH-1:0] v
   );
      return {{(DOUT_WIDTH-WIDTH){v[WIDTH-1]}}, v};
   endfunction

   // Decode phase: accept, fill/combine split, buffer slot, next phase
   always_comb begin
      w_acc     = en & din_valid;
      w_fill    = (r_phase < HB);
      w_comb    = w_acc & ~sync & ~w_fill;
      w_wr      = w_acc & (sync | w_fill);
      w_slot    = w_fill ? r_phase[SW-1:0] : SW'(r_phase - HB);
      w_wr_slot = sync ? '0 : w_slot;
      w_nxt     = (r_phase == LAST_PH) ? '0 : r_phase + PW'(1);
   end

   // Butterfly lanes: buffered sample A against current sample B
   always_comb begin
      for (int l = 0; l < DEPTH; l++) begin
         w_R_add[l] = sx(r_buf_R[w_slot][l]) + sx(din_R[l]);
         w_R_sub[l] = sx(r_buf_R[w_slot][l]) - sx(din_R[l]);
         w_Q_add[l] = sx(r_buf_Q[w_slot][l]) + sx(din_Q[l]);
         w_Q_sub[l] = sx(r_buf_Q[w_slot][l]) - sx(din_Q[l]);
      end
   end

   // Phase counter; sync restarts the frame with this block as phase 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase <= '0;
      end else if (w_acc) begin
         r_phase <= sync ? PW'(1) : w_nxt;
      end
   end

   // Delay buffer holds the first half-frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < HALF_BLKS; s++) begin
            for (int l = 0; l < DEPTH; l++) begin
               r_buf_R[s][l] <= '0;
               r_buf_Q[s][l] <= '0;
            end
         end
      end else if (w_wr) begin
         for (int l = 0; l < DEPTH; l++) begin
            r_buf_R[w_wr_slot][l] <= din_R[l];
            r_buf_Q[w_wr_slot][l] <= din_Q[l];
         end
      end
   end

   // Registered outputs; data only moves on a combine block
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         for (int l = 0; l < DEPTH; l++) begin
            dout_R_add[l] <= '0;
            dout_R_sub[l] <= '0;
            dout_Q_add[l] <= '0;
            dout_Q_sub[l] <= '0;
         end
      end else if (en) begin
         dout_valid <= w_comb;
         dout_last  <= w_comb & (r_phase == LAST_PH);
         if (w_comb) begin
            for (int l = 0; l < DEPTH; l++) begin
               dout_R_add[l] <= w_R_add[l];
               dout_R_sub[l] <= w_R_sub[l];
               dout_Q_add[l] <= w_Q_add[l];
               dout_Q_sub[l] <= w_Q_sub[l];
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_bfly_pre_sat.sv
// Scoreboard bench for fft_bfly_pre_sat.
// Frame-level reference model feeds an expected queue; a monitor pops it.
module tb_fft_bfly_pre_sat;

   localparam int W  = 13;
   localparam int DW = 14;
   localparam int D  = 4;
   localparam int H  = 2;
   localparam int NE = 1 + 4 * D;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic sync = 1'b0;
   logic din_valid = 1'b0;
   logic signed [W-1:0]  din_R [D];
   logic signed [W-1:0]  din_Q [D];
   logic                 dout_valid;
   logic                 dout_last;
   logic signed [DW-1:0] dout_R_add [D];
   logic signed [DW-1:0] dout_R_sub [D];
   logic signed [DW-1:0] dout_Q_add [D];
   logic signed [DW-1:0] dout_Q_sub [D];

   int n_cmp = 0;
   int n_err = 0;
   int n_valid = 0;
   int n_last = 0;
   int fR[$];
   int fQ[$];
   int exp_q[$];
   int last_ra[D];
   int last_qs[D];
   logic r_en_q = 1'b0;

   fft_bfly_pre_sat #(
      .WIDTH(W), .DOUT_WIDTH(DW), .DEPTH(D), .HALF_BLKS(H)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .sync(sync),
      .din_valid(din_valid), .din_R(din_R), .din_Q(din_Q),
      .dout_valid(dout_valid), .dout_last(dout_last),
      .dout_R_add(dout_R_add), .dout_R_sub(dout_R_sub),
      .dout_Q_add(dout_Q_add), .dout_Q_sub(dout_Q_sub)
   );

   always #5 clk = ~clk;

   always @(posedge clk) r_en_q <= en;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame model: keep the blocks of the current frame; the i-th block of
   // the second half pairs with the i-th block of the first half.
   task automatic model_accept(input int r[D], input int q[D], input bit s);
      int nb;
      int j;
      if (s) begin
         fR.delete();
         fQ.delete();
      end
      for (int l = 0; l < D; l++) begin
         fR.push_back(r[l]);
         fQ.push_back(q[l]);
      end
      nb = fR.size() / D;
      if (nb > H) begin
         j = nb - 1 - H;
         exp_q.push_back((nb == 2 * H) ? 1 : 0);
         for (int l = 0; l < D; l++) begin
            last_ra[l] = fR[j*D+l] + r[l];
            exp_q.push_back(last_ra[l]);
         end
         for (int l = 0; l < D; l++) exp_q.push_back(fR[j*D+l] - r[l]);
         for (int l = 0; l < D; l++) exp_q.push_back(fQ[j*D+l] + q[l]);
         for (int l = 0; l < D; l++) begin
            last_qs[l] = fQ[j*D+l] - q[l];
            exp_q.push_back(last_qs[l]);
         end
         if (nb == 2 * H) begin
            fR.delete();
            fQ.delete();
         end
      end
   endtask

   task automatic blk(input int r[D], input int q[D], input bit s);
      @(negedge clk);
      en = 1'b1;
      din_valid = 1'b1;
      sync = s;
      for (int l = 0; l < D; l++) begin
         din_R[l] = W'(r[l]);
         din_Q[l] = W'(q[l]);
      end
      model_accept(r, q, s);
   endtask

   task automatic rnd_blk(input bit s);
      int r[D];
      int q[D];
      for (int l = 0; l < D; l++) begin
         r[l] = int'($urandom_range(8191, 0)) - 4096;
         q[l] = int'($urandom_range(8191, 0)) - 4096;
      end
      blk(r, q, s);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         din_valid = 1'b0;
         sync = 1'b0;
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_valid"}, int'(dout_valid), 0);
      chk({nm, "_last"}, int'(dout_last), 0);
      for (int l = 0; l < D; l++) begin
         chk($sformatf("%s_lanes[%0d]", nm, l),
             int'(dout_R_add[l] != 0) + int'(dout_R_sub[l] != 0)
             + int'(dout_Q_add[l] != 0) + int'(dout_Q_sub[l] != 0), 0);
      end
   endtask

   // Monitor: every updated valid output pops one expected entry
   always @(negedge clk) begin
      if (!rst && r_en_q) begin
         if (dout_valid) begin
            n_valid++;
            if (dout_last) n_last++;
            if (exp_q.size() < NE) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_output: dout_valid=1 with nothing expected at %0t", $time);
            end else begin
               chk("dout_last", int'(dout_last), exp_q.pop_front());
               for (int l = 0; l < D; l++)
                  chk($sformatf("R_add[%0d]", l), dout_R_add[l], exp_q.pop_front());
               for (int l = 0; l < D; l++)
                  chk($sformatf("R_sub[%0d]", l), dout_R_sub[l], exp_q.pop_front());
               for (int l = 0; l < D; l++)
                  chk($sformatf("Q_add[%0d]", l), dout_Q_add[l], exp_q.pop_front());
               for (int l = 0; l < D; l++)
                  chk($sformatf("Q_sub[%0d]", l), dout_Q_sub[l], exp_q.pop_front());
            end
         end else begin
            chk("last_without_valid", int'(dout_last), 0);
         end
      end
   end

   initial begin
      int a[D];
      int b[D];
      int v0;
      int l0;
      for (int l = 0; l < D; l++) begin
         din_R[l] = '0;
         din_Q[l] = '0;
      end

      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      en = 1'b1;
      idle(1);
      chk_zero("post_reset");

      // basic pair
      a = '{100, 200, 300, 400}; b = '{5, -5, 7, -7};       blk(a, b, 0);
      a = '{10, 20, 30, 40};     b = '{-100, 50, 0, 1};     blk(a, b, 0);
      a = '{1, 2, 3, 4};         b = '{3, 3, -3, -3};       blk(a, b, 0);
      a = '{-1, -2, -3, -4};     b = '{9, -9, 4095, -4096}; blk(a, b, 0);
      idle(2);

      // extremes on R and Q
      a = '{4095, -4096, -4096, 4095}; b = '{4095, -4096, 4095, -4096}; blk(a, b, 0);
      a = '{4095, -4096, -4096, 4095}; b = '{-4096, 4095, -4096, 4095}; blk(a, b, 0);
      a = '{4095, -4096, 4095, -4096}; b = '{-4096, 4095, -4096, 4095}; blk(a, b, 0);
      a = '{4095, -4096, 4095, -4096}; b = '{4095, -4096, 4095, -4096}; blk(a, b, 0);
      idle(1);

      // gaps between blocks
      for (int k = 0; k < 4; k++) begin
         rnd_blk(0);
         idle(2);
      end

      // stall with a valid output pending
      repeat (3) rnd_blk(0);
      @(negedge clk);
      en = 1'b0;
      din_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_valid", int'(dout_valid), 1);
         for (int l = 0; l < D; l++) begin
            chk($sformatf("stall_R_add[%0d]", l), dout_R_add[l], last_ra[l]);
            chk($sformatf("stall_Q_sub[%0d]", l), dout_Q_sub[l], last_qs[l]);
         end
      end
      en = 1'b1;
      rnd_blk(0);
      idle(2);

      // sync abort on a combine-phase block
      repeat (3) rnd_blk(0);
      rnd_blk(1);
      repeat (3) rnd_blk(0);
      idle(2);

      // asynchronous reset mid-frame
      repeat (3) rnd_blk(0);
      idle(2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      fR.delete();
      fQ.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (4) rnd_blk(0);
      idle(2);

      // back-to-back frames
      v0 = n_valid;
      l0 = n_last;
      repeat (6 * H) rnd_blk(0);
      idle(2);
      chk("b2b_valid_count", n_valid - v0, 3 * H);
      chk("b2b_last_count", n_last - l0, 3);

      // random traffic: gaps, stalls with ignored sync, occasional sync
      repeat (60) begin
         if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(2, 1)));
         if ($urandom_range(5, 0) == 0) begin
            @(negedge clk);
            en = 1'b0;
            din_valid = 1'b1;
            sync = 1'b1;
            for (int l = 0; l < D; l++) din_R[l] = W'($urandom);
         end
         rnd_blk($urandom_range(11, 0) == 0);
      end
      idle(3);

      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
